// File: rtl/aes_stream_packer_if.sv
// Stream bundle for aes_stream_packer.
// Carries the narrow input stream (s_*) and the block-wide output stream (m_*).
//   slave  : the packer side (consumes s_*, produces m_*)
//   master : the surrounding logic side (produces s_*, consumes m_*)
// Handshake: both streams follow valid/ready rules. A beat or block transfers on a
// rising clock edge where valid and ready are both high. Once valid is raised, the
// producer holds valid and its payload stable until that transfer.
interface aes_stream_packer_if #(
  parameter int BLOCK_W = 128,
  parameter int IN_W    = 8,
  parameter int CW      = $clog2(BLOCK_W / IN_W + 1)
);
  logic [IN_W-1:0]    s_tdata;
  logic               s_tvalid;
  logic               s_tlast;
  logic               s_tready;
  logic [BLOCK_W-1:0] m_tdata;
  logic               m_tvalid;
  logic               m_tlast;
  logic [CW-1:0]      m_tpad;
  logic               m_tready;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast, m_tpad
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast, m_tpad
  );
endinterface

// File: rtl/aes_stream_packer.sv
// aes_stream_packer: packs IN_W-bit beats into BLOCK_W-bit blocks for the AES datapath.
// A partial block is flushed on s_tlast or after TimeoutCycles idle cycles, and padded
// with zeros (PAD_MODE 0) or PKCS#7 lane values (PAD_MODE 1).
// Ports:
//   Clk, Rst       clock, synchronous active-high reset
//   En             enable; low discards any held data and returns to FILL
//   TimeoutCycles  idle cycles before a partial block is flushed; 0 disables the timeout
//   bus            stream bundle (slave side): s_* narrow input, m_* block output
//   o_fill         lanes currently held
//   o_timeout      one-cycle pulse when a timeout flush starts
//   o_state        current FSM state (FILL=0, PAD=1, OUT=2) for observation
// The first accepted beat of a block lands in the most significant lane.
module aes_stream_packer #(
  parameter int BLOCK_W   = 128,
  parameter int IN_W      = 8,
  parameter int TIMEOUT_W = 16,
  parameter int PAD_MODE  = 0,
  localparam int LANES    = BLOCK_W / IN_W,
  localparam int CW       = $clog2(LANES + 1)
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 En,
  input  logic [TIMEOUT_W-1:0] TimeoutCycles,
  aes_stream_packer_if.slave   bus,
  output logic [CW-1:0]        o_fill,
  output logic                 o_timeout,
  output logic [1:0]           o_state
);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_PAD  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        fill_q, fill_d;
  logic [BLOCK_W-1:0]   data_q, data_d;
  logic                 last_q, last_d;
  logic [CW-1:0]        pad_q, pad_d;
  logic                 pend_q, pend_d;   // PKCS#7: a full frame still owes an all-pad block
  logic [TIMEOUT_W-1:0] idle_q, idle_d;
  logic                 tout_q, tout_d;

  logic                 s_ready;
  logic                 accept;
  logic [TIMEOUT_W-1:0] idle_inc;
  logic [IN_W-1:0]      pad_lane;

  assign s_ready  = (state_q == S_FILL) && En && !Rst;
  assign accept   = bus.s_tvalid && s_ready;
  assign idle_inc = (idle_q == '1) ? idle_q : idle_q + TIMEOUT_W'(1);
  assign pad_lane = (PAD_MODE == 1) ? IN_W'(LANES - int'(fill_q)) : '0;

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    data_d  = data_q;
    last_d  = last_q;
    pad_d   = pad_q;
    pend_d  = pend_q;
    idle_d  = idle_q;
    tout_d  = 1'b0;

    case (state_q)
      S_FILL: begin
        if (accept) begin
          for (int l = 0; l < LANES; l++) begin
            if (fill_q == CW'(l)) data_d[BLOCK_W-1-l*IN_W -: IN_W] = bus.s_tdata;
          end
          fill_d = fill_q + CW'(1);
          idle_d = '0;
          if (fill_q == CW'(LANES - 1)) begin
            state_d = S_OUT;
            pad_d   = '0;
            last_d  = bus.s_tlast;
            // PKCS#7 always pads, so a frame ending exactly on a block boundary
            // needs one extra block made only of padding.
            pend_d  = bus.s_tlast && (PAD_MODE == 1);
          end else if (bus.s_tlast) begin
            state_d = S_PAD;
          end
        end else if (fill_q == '0) begin
          idle_d = '0;
        end else if (TimeoutCycles != '0) begin
          idle_d = idle_inc;
          // ">=" so that lowering TimeoutCycles mid-count still fires.
          if (idle_inc >= TimeoutCycles) begin
            state_d = S_PAD;
            tout_d  = 1'b1;
            idle_d  = '0;
          end
        end
      end

      S_PAD: begin
        for (int l = 0; l < LANES; l++) begin
          if (l >= int'(fill_q)) data_d[BLOCK_W-1-l*IN_W -: IN_W] = pad_lane;
        end
        pad_d   = CW'(LANES) - fill_q;
        last_d  = 1'b1;
        state_d = S_OUT;
      end

      S_OUT: begin
        if (bus.m_tready) begin
          fill_d = '0;
          if (pend_q) begin
            pend_d  = 1'b0;
            state_d = S_PAD;
          end else begin
            state_d = S_FILL;
          end
        end
      end

      default: state_d = S_FILL;
    endcase

    // Disable wins over everything, including an untaken block.
    if (!En) begin
      state_d = S_FILL;
      fill_d  = '0;
      pend_d  = 1'b0;
      idle_d  = '0;
      tout_d  = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_FILL;
      fill_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      pad_q   <= '0;
      pend_q  <= 1'b0;
      idle_q  <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      last_q  <= last_d;
      pad_q   <= pad_d;
      pend_q  <= pend_d;
      idle_q  <= idle_d;
      tout_q  <= tout_d;
    end
  end

  assign bus.s_tready = s_ready;
  assign bus.m_tdata  = data_q;
  assign bus.m_tvalid = (state_q == S_OUT);
  assign bus.m_tlast  = last_q;
  assign bus.m_tpad   = pad_q;
  assign o_fill       = fill_q;
  assign o_timeout    = tout_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_aes_stream_packer.sv
// Bench for aes_stream_packer: one zero-padding and one PKCS#7 instance; `sel` picks
// which one receives stimulus and is checked. A queue-based block model predicts
// every output; directed tests add literal expectations for data and latency.
module tb_aes_stream_packer;
  localparam int BW    = 128;
  localparam int IW    = 8;
  localparam int LANES = BW / IW;
  localparam int CW    = $clog2(LANES + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic [15:0] to_cyc = '0;
  logic sel = 1'b0;
  always #5 clk = ~clk;

  logic [IW-1:0] drv_tdata  = '0;
  logic          drv_tvalid = 1'b0;
  logic          drv_tlast  = 1'b0;
  logic          drv_mready = 1'b1;

  aes_stream_packer_if #(.BLOCK_W(BW), .IN_W(IW)) if0 ();
  aes_stream_packer_if #(.BLOCK_W(BW), .IN_W(IW)) if1 ();

  logic [CW-1:0] fill0, fill1;
  logic          tout0, tout1;
  logic [1:0]    st0, st1;

  aes_stream_packer #(.BLOCK_W(BW), .IN_W(IW), .TIMEOUT_W(16), .PAD_MODE(0)) dut0 (
    .Clk(clk), .Rst(rst), .En(en), .TimeoutCycles(to_cyc), .bus(if0.slave),
    .o_fill(fill0), .o_timeout(tout0), .o_state(st0));

  aes_stream_packer #(.BLOCK_W(BW), .IN_W(IW), .TIMEOUT_W(16), .PAD_MODE(1)) dut1 (
    .Clk(clk), .Rst(rst), .En(en), .TimeoutCycles(to_cyc), .bus(if1.slave),
    .o_fill(fill1), .o_timeout(tout1), .o_state(st1));

  assign if0.s_tdata  = drv_tdata;
  assign if1.s_tdata  = drv_tdata;
  assign if0.s_tlast  = drv_tlast;
  assign if1.s_tlast  = drv_tlast;
  assign if0.s_tvalid = drv_tvalid && !sel;
  assign if1.s_tvalid = drv_tvalid && sel;
  assign if0.m_tready = drv_mready;
  assign if1.m_tready = drv_mready;

  logic          a_s_tready, a_m_tvalid, a_m_tlast, a_o_timeout;
  logic [BW-1:0] a_m_tdata;
  logic [CW-1:0] a_m_tpad, a_o_fill;
  assign a_s_tready  = sel ? if1.s_tready : if0.s_tready;
  assign a_m_tvalid  = sel ? if1.m_tvalid : if0.m_tvalid;
  assign a_m_tlast   = sel ? if1.m_tlast  : if0.m_tlast;
  assign a_m_tdata   = sel ? if1.m_tdata  : if0.m_tdata;
  assign a_m_tpad    = sel ? if1.m_tpad   : if0.m_tpad;
  assign a_o_fill    = sel ? fill1 : fill0;
  assign a_o_timeout = sel ? tout1 : tout0;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Block-level model: accepted beats accumulate in cur; a flush turns them into a
  // finished block in exp_q. gap = invalid cycles (the padding cycle) before the
  // block becomes visible.
  typedef struct packed {
    logic [BW-1:0] data;
    logic [CW-1:0] pad;
    logic          last;
    logic          gap;
  } blk_t;

  logic [IW-1:0] cur[$];
  blk_t          exp_q[$];
  int            gap_cnt = 0;
  int            idle    = 0;
  logic          exp_to  = 1'b0;

  function automatic blk_t make_blk(input logic last, input logic gap);
    blk_t b;
    int n;
    logic [IW-1:0] v;
    n = cur.size();
    b.data = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < n) v = cur[i];
      else       v = sel ? IW'(LANES - n) : '0;
      b.data[BW-1-i*IW -: IW] = v;
    end
    b.pad  = CW'(LANES - n);
    b.last = last;
    b.gap  = gap;
    return b;
  endfunction

  always @(posedge clk) begin
    exp_to = 1'b0;
    if (rst || !en) begin
      cur.delete();
      exp_q.delete();
      idle    = 0;
      gap_cnt = 0;
    end else if (exp_q.size() != 0) begin
      if (gap_cnt != 0) gap_cnt--;
      else if (drv_mready) begin
        void'(exp_q.pop_front());
        if (exp_q.size() != 0) gap_cnt = int'(exp_q[0].gap);
      end
    end else begin
      if (drv_tvalid) begin
        cur.push_back(drv_tdata);
        idle = 0;
        if (cur.size() == LANES) begin
          exp_q.push_back(make_blk(drv_tlast, 1'b0));
          cur.delete();
          if (drv_tlast && sel) exp_q.push_back(make_blk(1'b1, 1'b1));
        end else if (drv_tlast) begin
          exp_q.push_back(make_blk(1'b1, 1'b1));
          cur.delete();
        end
      end else if (cur.size() == 0) begin
        idle = 0;
      end else if (to_cyc != 0) begin
        if (idle < 65535) idle++;
        if (idle >= int'(to_cyc)) begin
          exp_q.push_back(make_blk(1'b1, 1'b1));
          cur.delete();
          exp_to = 1'b1;
          idle   = 0;
        end
      end
      if (exp_q.size() != 0) gap_cnt = int'(exp_q[0].gap);
    end
  end

  always @(negedge clk) begin
    logic exp_valid;
    exp_valid = (exp_q.size() != 0) && (gap_cnt == 0);
    check("s_tready", a_s_tready, !rst && en && (exp_q.size() == 0));
    check("m_tvalid", a_m_tvalid, exp_valid);
    check("o_timeout", a_o_timeout, exp_to);
    if (exp_valid) begin
      check("m_tdata", a_m_tdata, exp_q[0].data);
      check("m_tpad", a_m_tpad, exp_q[0].pad);
      check("m_tlast", a_m_tlast, exp_q[0].last);
    end
    if (!rst && exp_q.size() == 0) check("o_fill", a_o_fill, cur.size());
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [IW-1:0] d, input logic last);
    int n;
    n = 0;
    drv_tdata  = d;
    drv_tlast  = last;
    drv_tvalid = 1'b1;
    while (!a_s_tready && n < 100) begin
      tick;
      n++;
    end
    if (n >= 100) fail("beat_accept_wait");
    tick;
    drv_tvalid = 1'b0;
    drv_tlast  = 1'b0;
  endtask

  task automatic send_seq(input logic [IW-1:0] start, input int count, input logic last);
    for (int i = 0; i < count; i++) send_beat(IW'(start + i), last && (i == count - 1));
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!a_m_tvalid && n < 50) begin
      tick;
      n++;
    end
    if (n >= 50) fail("m_tvalid_wait");
  endtask

  task automatic wait_timeout(output int n);
    n = 0;
    while (!a_o_timeout && n < 50) begin
      tick;
      n++;
    end
    if (n >= 50) fail("o_timeout_wait");
  endtask

  task automatic check_block(input string name, input logic [BW-1:0] d, input int pad, input logic last);
    check({name, "_valid"}, a_m_tvalid, 1'b1);
    check({name, "_data"}, a_m_tdata, d);
    check({name, "_pad"}, a_m_tpad, pad);
    check({name, "_last"}, a_m_tlast, last);
  endtask

  task automatic switch_dut(input logic s);
    en = 1'b0;
    tick;
    tick;
    sel = s;
    en  = 1'b1;
    tick;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int n;
    repeat (3) tick;
    check("rst_m_tvalid", a_m_tvalid, 1'b0);
    check("rst_m_tdata", a_m_tdata, '0);
    check("rst_m_tpad", a_m_tpad, '0);
    check("rst_m_tlast", a_m_tlast, 1'b0);
    check("rst_o_fill", a_o_fill, '0);
    check("rst_o_timeout", a_o_timeout, 1'b0);
    check("rst_s_tready", a_s_tready, 1'b0);
    rst = 1'b0;
    en  = 1'b1;
    tick;

    // full block, no padding
    send_seq(8'h00, 16, 1'b0);
    wait_valid(n);
    check("full_latency", n, 0);
    check_block("full", 128'h000102030405060708090a0b0c0d0e0f, 0, 1'b0);
    tick;
    check("full_back_to_fill", a_s_tready, 1'b1);

    // s_tlast flush, zero padding
    send_seq(8'h01, 5, 1'b1);
    wait_valid(n);
    check("zpad_latency", n, 1);
    check_block("zpad", 128'h0102030405_0000000000000000000000, 11, 1'b1);
    tick;

    // PKCS#7
    switch_dut(1'b1);
    send_seq(8'h01, 5, 1'b1);
    wait_valid(n);
    check("pkcs_latency", n, 1);
    check_block("pkcs", 128'h0102030405_0b0b0b0b0b0b0b0b0b0b0b, 11, 1'b1);
    tick;
    send_seq(8'h00, 16, 1'b1);
    wait_valid(n);
    check_block("pkcs_full", 128'h000102030405060708090a0b0c0d0e0f, 0, 1'b1);
    tick;
    check("pkcs_pad_gap", a_m_tvalid, 1'b0);
    wait_valid(n);
    check("pkcs_allpad_latency", n, 1);
    check_block("pkcs_allpad", 128'h10101010101010101010101010101010, 16, 1'b1);
    tick;

    // idle timeout
    switch_dut(1'b0);
    to_cyc = 16'd10;
    send_seq(8'ha1, 3, 1'b0);
    wait_timeout(n);
    check("tmo_cycles", n, 10);
    tick;
    check("tmo_pulse_width", a_o_timeout, 1'b0);
    check_block("tmo", 128'ha1a2a3_00000000000000000000000000, 13, 1'b1);
    tick;

    // a beat on idle cycle 9 restarts the count
    send_seq(8'hb1, 3, 1'b0);
    repeat (8) tick;
    send_beat(8'hb4, 1'b0);
    wait_timeout(n);
    check("tmo_restart_cycles", n, 10);
    tick;
    check_block("tmo_restart", 128'hb1b2b3b4_000000000000000000000000, 12, 1'b1);
    tick;

    // lowering TimeoutCycles below the running count fires at once
    to_cyc = 16'd20;
    send_seq(8'hc1, 2, 1'b0);
    repeat (5) tick;
    to_cyc = 16'd4;
    wait_timeout(n);
    check("tmo_lowered_cycles", n, 1);
    tick;
    check_block("tmo_lowered", 128'hc1c2_0000000000000000000000000000, 14, 1'b1);
    tick;

    // back-pressure: block held stable, no timeout while waiting
    to_cyc = 16'd3;
    drv_mready = 1'b0;
    send_seq(8'h40, 16, 1'b0);
    repeat (20) begin
      tick;
      check("stall_s_tready", a_s_tready, 1'b0);
      check("stall_o_timeout", a_o_timeout, 1'b0);
    end
    check_block("stall", 128'h404142434445464748494a4b4c4d4e4f, 0, 1'b0);
    drv_mready = 1'b1;
    tick;
    check("stall_release_valid", a_m_tvalid, 1'b0);
    check("stall_release_ready", a_s_tready, 1'b1);

    // En drop mid-fill and with a pending block
    to_cyc = 16'd0;
    send_seq(8'h50, 7, 1'b0);
    check("en_fill_before", a_o_fill, 7);
    en = 1'b0;
    tick;
    check("en_fill_cleared", a_o_fill, 0);
    check("en_valid_cleared", a_m_tvalid, 1'b0);
    en = 1'b1;
    tick;
    drv_mready = 1'b0;
    send_seq(8'h60, 16, 1'b0);
    check("en_out_valid", a_m_tvalid, 1'b1);
    en = 1'b0;
    tick;
    check("en_out_discard", a_m_tvalid, 1'b0);
    check("en_out_fill", a_o_fill, 0);
    en = 1'b1;
    drv_mready = 1'b1;
    tick;
    send_seq(8'h20, 16, 1'b0);
    wait_valid(n);
    check_block("en_repack", 128'h202122232425262728292a2b2c2d2e2f, 0, 1'b0);
    tick;
    repeat (3) tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
